// File: rtl/motor_cmd_ramp.sv
// Slew-rate limiter for the 8-bit sign-magnitude motor speed command, with forced dwell at zero
// before reversal. Optional hall-edge stall detector enabled by defining MOTOR_RAMP_STALL_EN.
module motor_cmd_ramp #(
    parameter int unsigned STEP_DIV    = 1000,
    parameter int unsigned STEP        = 1,
    parameter int unsigned DWELL       = 4,
    parameter int unsigned STALL_TICKS = 5_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] cmd_in,
    input  logic       h1,
    input  logic       h2,
    input  logic       h3,
    output logic [7:0] cmd_out,
    output logic       busy,
    output logic       stall
);

    localparam int unsigned DIV_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam int unsigned DW_W  = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [7:0]  STEP8 = 8'(STEP);

    typedef enum logic [1:0] {StRun, StDwell, StStall} state_e;

    state_e           state_q, state_d;
    logic [DIV_W-1:0] div_q;
    logic [DW_W-1:0]  dwell_q, dwell_d;
    logic             cur_sign_q, cur_sign_d;
    logic [6:0]       cur_mag_q, cur_mag_d;

    logic       tick;
    logic       tgt_sign;
    logic [6:0] tgt_mag;
    logic       reversing;
    logic [7:0] cur8, tgt8, up8, dn8;
    logic [6:0] step_mag;
    logic [6:0] down_to_zero;
    logic       stall_hit;

    assign tick      = (div_q == DIV_W'(STEP_DIV - 1));
    assign tgt_sign  = cmd_in[7];
    assign tgt_mag   = cmd_in[6:0];
    // A zero-magnitude target never asks for a sign change.
    assign reversing = (tgt_mag != 7'd0) && (tgt_sign != cur_sign_q);

    always_comb begin
        cur8         = {1'b0, cur_mag_q};
        tgt8         = {1'b0, tgt_mag};
        up8          = cur8 + STEP8;
        dn8          = cur8 - STEP8;
        step_mag     = tgt_mag;
        down_to_zero = 7'd0;
        if (cur8 < tgt8) begin
            step_mag = (up8 > tgt8) ? tgt_mag : up8[6:0];
        end else if (cur8 >= tgt8 + STEP8) begin
            step_mag = dn8[6:0];
        end
        if (cur8 >= STEP8) begin
            down_to_zero = dn8[6:0];
        end
    end

`ifdef MOTOR_RAMP_STALL_EN
    localparam int unsigned SC_W = $clog2(STALL_TICKS + 1);

    logic [2:0]      h_meta_q, h_sync_q, h_prev_q;
    logic [SC_W-1:0] stall_cnt_q;
    logic            hall_edge;

    assign hall_edge = (h_sync_q != h_prev_q);
    assign stall_hit = (stall_cnt_q == SC_W'(STALL_TICKS));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            h_meta_q    <= 3'b000;
            h_sync_q    <= 3'b000;
            h_prev_q    <= 3'b000;
            stall_cnt_q <= '0;
        end else begin
            h_meta_q <= {h1, h2, h3};
            h_sync_q <= h_meta_q;
            h_prev_q <= h_sync_q;
            if (hall_edge || (cur_mag_q == 7'd0)) begin
                stall_cnt_q <= '0;
            end else if (!stall_hit) begin
                stall_cnt_q <= stall_cnt_q + 1'b1;
            end
        end
    end
`else
    logic unused_stall_cfg;
    assign unused_stall_cfg = h1 ^ h2 ^ h3 ^ (STALL_TICKS == 0);
    assign stall_hit        = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= StRun;
            div_q      <= '0;
            dwell_q    <= '0;
            cur_sign_q <= 1'b0;
            cur_mag_q  <= 7'd0;
        end else begin
            state_q    <= state_d;
            div_q      <= tick ? '0 : div_q + 1'b1;
            dwell_q    <= dwell_d;
            cur_sign_q <= cur_sign_d;
            cur_mag_q  <= cur_mag_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        dwell_d    = dwell_q;
        cur_sign_d = cur_sign_q;
        cur_mag_d  = cur_mag_q;
        unique case (state_q)
            StRun: begin
                if (tick) begin
                    if (!reversing) begin
                        cur_mag_d = step_mag;
                    end else if (cur_mag_q != 7'd0) begin
                        cur_mag_d = down_to_zero;
                    end else begin
                        state_d = StDwell;
                        dwell_d = '0;
                    end
                end
            end
            StDwell: begin
                if (tick) begin
                    if (!reversing) begin
                        state_d = StRun;
                        dwell_d = '0;
                    end else if (dwell_q == DW_W'(DWELL - 1)) begin
                        cur_sign_d = tgt_sign;
                        state_d    = StRun;
                        dwell_d    = '0;
                    end else begin
                        dwell_d = dwell_q + 1'b1;
                    end
                end
            end
            StStall: begin
                cur_mag_d = 7'd0;
                if (tgt_mag == 7'd0) begin
                    state_d = StRun;
                end
            end
            default: state_d = StRun;
        endcase
        // Stall overrides any step scheduled on the same cycle.
        if (stall_hit && (state_q != StStall)) begin
            state_d   = StStall;
            cur_mag_d = 7'd0;
            dwell_d   = '0;
        end
    end

    always_comb begin
        cmd_out = {cur_sign_q, cur_mag_q};
        busy    = (state_q != StRun) || (cur_mag_q != tgt_mag) || reversing;
        stall   = (state_q == StStall);
    end

endmodule

// File: tb/tb_motor_cmd_ramp.sv
// Directed self-checking bench for motor_cmd_ramp (STEP_DIV=4, STEP=8, DWELL=2, STALL_TICKS=64).
module tb_motor_cmd_ramp;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] cmd_in;
    logic       h1, h2, h3;
    logic [7:0] cmd_out;
    logic       busy;
    logic       stall;

    int tests_run = 0;
    int tests_failed = 0;

    logic [7:0] rev_exp [0:6];

    motor_cmd_ramp #(
        .STEP_DIV   (4),
        .STEP       (8),
        .DWELL      (2),
        .STALL_TICKS(64)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .cmd_in (cmd_in),
        .h1     (h1),
        .h2     (h2),
        .h3     (h3),
        .cmd_out(cmd_out),
        .busy   (busy),
        .stall  (stall)
    );

    always #5 clk = ~clk;

    task automatic edges(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One reset edge with a zero command, released on a falling edge.
    task automatic do_reset();
        @(negedge clk);
        rst_n  = 1'b0;
        cmd_in = 8'h00;
        h1 = 1'b0; h2 = 1'b0; h3 = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n  = 1'b0;
        cmd_in = 8'h00;
        h1 = 1'b0; h2 = 1'b0; h3 = 1'b0;
        edges(2);
        tests_run++;
        if (cmd_out !== 8'h00) begin
            tests_failed++;
            $display("FAIL reset_cmd_out got %h want 00", cmd_out);
        end
        tests_run++;
        if (busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_busy got %b want 0", busy);
        end
        tests_run++;
        if (stall !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_stall got %b want 0", stall);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_ramp_up();
        do_reset();
        cmd_in = 8'h20;
        for (int k = 1; k <= 4; k++) begin
            edges(3);
            tests_run++;
            if (cmd_out !== 8'(8 * (k - 1))) begin
                tests_failed++;
                $display("FAIL ramp_hold_%0d got %h want %h", k, cmd_out, 8'(8 * (k - 1)));
            end
            edges(1);
            tests_run++;
            if (cmd_out !== 8'(8 * k)) begin
                tests_failed++;
                $display("FAIL ramp_step_%0d got %h want %h", k, cmd_out, 8'(8 * k));
            end
        end
        tests_run++;
        if (busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL ramp_busy_done got %b want 0", busy);
        end
    endtask

    task automatic test_partial_and_saturate();
        do_reset();
        cmd_in = 8'h05;
        edges(3);
        tests_run++;
        if (busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL partial_busy got %b want 1", busy);
        end
        edges(1);
        tests_run++;
        if (cmd_out !== 8'h05) begin
            tests_failed++;
            $display("FAIL partial_step got %h want 05", cmd_out);
        end
        cmd_in = 8'h7F;
        // 5 -> 127 in steps of 8 needs 16 ticks.
        edges(60);
        tests_run++;
        if (cmd_out !== 8'h7D) begin
            tests_failed++;
            $display("FAIL sat_before_last got %h want 7d", cmd_out);
        end
        edges(4);
        tests_run++;
        if (cmd_out !== 8'h7F) begin
            tests_failed++;
            $display("FAIL sat_reach got %h want 7f", cmd_out);
        end
        edges(16);
        tests_run++;
        if (cmd_out !== 8'h7F || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL sat_hold got %h/%b want 7f/0", cmd_out, busy);
        end
    endtask

    task automatic test_reversal();
        rev_exp[0] = 8'h08; rev_exp[1] = 8'h00; rev_exp[2] = 8'h00; rev_exp[3] = 8'h00;
        rev_exp[4] = 8'h80; rev_exp[5] = 8'h88; rev_exp[6] = 8'h90;
        do_reset();
        cmd_in = 8'h10;
        edges(8);
        tests_run++;
        if (cmd_out !== 8'h10) begin
            tests_failed++;
            $display("FAIL rev_settle got %h want 10", cmd_out);
        end
        cmd_in = 8'h90;
        for (int t = 0; t < 7; t++) begin
            edges(4);
            tests_run++;
            if (cmd_out !== rev_exp[t]) begin
                tests_failed++;
                $display("FAIL rev_tick_%0d got %h want %h", t + 1, cmd_out, rev_exp[t]);
            end
            if (t == 2) begin
                tests_run++;
                if (busy !== 1'b1) begin
                    tests_failed++;
                    $display("FAIL rev_dwell_busy got %b want 1", busy);
                end
            end
        end
        tests_run++;
        if (busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL rev_done_busy got %b want 0", busy);
        end
    endtask

    task automatic test_dwell_abort();
        int sign_seen;
        sign_seen = 0;
        do_reset();
        cmd_in = 8'h10;
        edges(8);
        cmd_in = 8'h90;
        edges(12);
        // Now in dwell at zero; target returns to the old sign.
        cmd_in = 8'h10;
        for (int i = 0; i < 24; i++) begin
            edges(1);
            if (cmd_out[7] !== 1'b0) sign_seen++;
        end
        tests_run++;
        if (sign_seen !== 0) begin
            tests_failed++;
            $display("FAIL abort_no_flip got %0d flipped cycles want 0", sign_seen);
        end
        tests_run++;
        if (cmd_out !== 8'h10) begin
            tests_failed++;
            $display("FAIL abort_final got %h want 10", cmd_out);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        cmd_in = 8'h20;
        edges(12);
        tests_run++;
        if (cmd_out !== 8'h18) begin
            tests_failed++;
            $display("FAIL mid_pre got %h want 18", cmd_out);
        end
        rst_n  = 1'b0;
        cmd_in = 8'h00;
        edges(1);
        tests_run++;
        if (cmd_out !== 8'h00 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL mid_reset got %h/%b want 00/0", cmd_out, busy);
        end
        rst_n  = 1'b1;
        cmd_in = 8'h20;
        edges(3);
        tests_run++;
        if (cmd_out !== 8'h00) begin
            tests_failed++;
            $display("FAIL mid_restart_hold got %h want 00", cmd_out);
        end
        edges(1);
        tests_run++;
        if (cmd_out !== 8'h08) begin
            tests_failed++;
            $display("FAIL mid_restart_step got %h want 08", cmd_out);
        end
    endtask

`ifdef MOTOR_RAMP_STALL_EN
    task automatic test_stall();
        do_reset();
        cmd_in = 8'h40;
        edges(66);
        tests_run++;
        if (stall !== 1'b0) begin
            tests_failed++;
            $display("FAIL stall_early got %b want 0", stall);
        end
        edges(6);
        tests_run++;
        if (stall !== 1'b1 || cmd_out !== 8'h00) begin
            tests_failed++;
            $display("FAIL stall_enter got %b/%h want 1/00", stall, cmd_out);
        end
        edges(8);
        tests_run++;
        if (stall !== 1'b1 || cmd_out !== 8'h00) begin
            tests_failed++;
            $display("FAIL stall_hold got %b/%h want 1/00", stall, cmd_out);
        end
        cmd_in = 8'h00;
        edges(1);
        tests_run++;
        if (stall !== 1'b0) begin
            tests_failed++;
            $display("FAIL stall_clear got %b want 0", stall);
        end
    endtask

    task automatic test_hall_toggle();
        int stall_seen;
        stall_seen = 0;
        do_reset();
        cmd_in = 8'h40;
        for (int i = 1; i <= 300; i++) begin
            edges(1);
            if (stall !== 1'b0) stall_seen++;
            if (i % 32 == 0) h1 = ~h1;
        end
        tests_run++;
        if (stall_seen !== 0) begin
            tests_failed++;
            $display("FAIL hall_no_stall got %0d stalled cycles want 0", stall_seen);
        end
        tests_run++;
        if (cmd_out !== 8'h40) begin
            tests_failed++;
            $display("FAIL hall_cmd got %h want 40", cmd_out);
        end
    endtask
`else
    task automatic test_no_stall_feature();
        int stall_seen;
        stall_seen = 0;
        do_reset();
        cmd_in = 8'h40;
        for (int i = 0; i < 300; i++) begin
            edges(1);
            if (stall !== 1'b0) stall_seen++;
        end
        tests_run++;
        if (stall_seen !== 0) begin
            tests_failed++;
            $display("FAIL nostall_flag got %0d stalled cycles want 0", stall_seen);
        end
        tests_run++;
        if (cmd_out !== 8'h40) begin
            tests_failed++;
            $display("FAIL nostall_cmd got %h want 40", cmd_out);
        end
    endtask
`endif

    initial begin
        rst_n  = 1'b0;
        cmd_in = 8'h00;
        h1 = 1'b0; h2 = 1'b0; h3 = 1'b0;
        test_reset();
        test_ramp_up();
        test_partial_and_saturate();
        test_reversal();
        test_dwell_abort();
        test_reset_mid();
`ifdef MOTOR_RAMP_STALL_EN
        test_stall();
        test_hall_toggle();
`else
        test_no_stall_feature();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/motor_cmd_ramp.md
# motor_cmd_ramp

Slew-rate limiter for the 8-bit sign-magnitude speed command that feeds the PWM/commutation stage (`motor7bitpwm` → `motorV`). It sits directly upstream of the PWM generator. It accepts a raw target command, ramps the magnitude toward it at a fixed rate, and forces a ramp-to-zero plus dwell before any direction reversal. An optional hall-edge stall detector cuts drive when the rotor stops turning under a nonzero command.

## Interface
- `STEP_DIV`, 1000: clk cycles per ramp step tick (≥1).
- `STEP`, 1: magnitude change per tick (1..127).
- `DWELL`, 4: ticks held at zero magnitude before the sign flips (≥1).
- `STALL_TICKS`, 5_000_000: clk cycles without a hall edge before stall is declared (stall feature only).

- `clk`  in  1  system clock, all logic on rising edge.
- `rst_n`  in  1  synchronous reset, active-low.
- `cmd_in`  in  8  target command; bit7 = direction, bits6:0 = magnitude.
- `h1`, `h2`, `h3`  in  1 each  raw hall inputs, asynchronous. Ignored when the stall feature is compiled out.
- `cmd_out`  out  8  ramped command, same format as `cmd_in`, registered. Drives the PWM input.
- `busy`  out  1  high while `cmd_out` ≠ effective target, or while in DWELL/STALL.
- `stall`  out  1  stall flag. Tied 0 when the feature is compiled out.

## Operation
- Prescaler counts 0..`STEP_DIV`-1. `tick` is a one-cycle pulse when the count equals `STEP_DIV`-1; the count then wraps to 0.
- Internal state: `cur_sign`, `cur_mag[6:0]`. `cmd_out = {cur_sign, cur_mag}`.
- A target with magnitude 0 never requests a sign change; `cur_sign` is retained.
- States:
  - RUN
    - Same sign, or target magnitude 0: on `tick`, step toward the target magnitude.
      - Increase: `cur_mag = min(cur_mag+STEP, tgt_mag)`.
      - Decrease: `cur_mag = max(cur_mag-STEP, tgt_mag)`.
      - Arithmetic is 8-bit, so there is no wrap; the result never exceeds 127.
    - Opposite sign with nonzero target magnitude: on `tick`, `cur_mag = max(cur_mag-STEP, 0)`.
    - Opposite sign and `cur_mag` = 0: go to DWELL on the next `tick`, with dwell counter = 0.
  - DWELL
    - `cur_mag` stays 0 and the dwell counter increments per `tick`.
    - After `DWELL` ticks, set `cur_sign` to the target sign and return to RUN. Ramping resumes on the following tick.
    - If the target returns to the old sign, or its magnitude goes to 0, during DWELL: abort to RUN with the sign unchanged.
  - STALL: compiled in only; see Configuration.
- `cmd_in` is sampled every cycle and acts only on ticks. Target changes between ticks are not latched; the last value before the tick wins.
- `busy` is combinational from registered state and `cmd_in`.

## Timing
- Reset (`rst_n`=0 at a clk edge):
  - `cmd_out` = 8'h00, `busy` = 0, `stall` = 0.
  - State RUN; prescaler, dwell and stall counters cleared.
  - Hall synchronizers cleared.
- Reset mid-ramp or mid-dwell: `cmd_out` drops to 0 on that edge; there is no ramp-down.
- Latency: `cmd_out` changes one clk after the `tick` cycle. The first tick after reset is at cycle `STEP_DIV`.
- Full-scale ramp 0→127 takes ceil(127/`STEP`) ticks.
- Reversal from magnitude M takes ceil(M/`STEP`) + 1 + `DWELL` ticks to reach opposite-sign zero, then ramps up.
- Simultaneous stall detection and `tick`: stall takes priority.

## Configuration
- Macro: `MOTOR_RAMP_STALL_EN`.
- Defined:
  - `h1`..`h3` each pass through a 2-flop synchronizer. Any change of the synchronized triple is a hall edge.
  - A cycle counter clears on every hall edge and whenever `cur_mag` = 0; otherwise it increments, saturating.
  - Reaching `STALL_TICKS` enters STALL: `cur_mag` is forced to 0 on the next edge (no ramp) and `stall` = 1.
  - STALL exits to RUN only after one cycle with `cmd_in[6:0]` = 0; `stall` clears on that transition.
- Undefined:
  - No synchronizers, no counter, no STALL state.
  - `stall` is constant 0; hall inputs are unused.

## Test plan
Bench parameters: `STEP_DIV`=4, `STEP`=8, `DWELL`=2, `STALL_TICKS`=64.

1. Ramp up: after reset, hold `cmd_in`=8'h20 → `cmd_out` is 8'h08, 8'h10, 8'h18, 8'h20 following cycles 4, 8, 12, 16. `busy` falls once 8'h20 is reached.
2. Partial step: from 8'h00, `cmd_in`=8'h05 → `cmd_out`=8'h05 after the first tick. Then `cmd_in`=8'h7F → `cmd_out` saturates at 8'h7F and never wraps.
3. Reversal: settled at 8'h10, `cmd_in`=8'h90 →
   - `cmd_out` sequence: 8'h08, 8'h00, 8'h00 for 1+2 dwell ticks, then 8'h80, 8'h88, 8'h90.
   - Repeat with `cmd_in` returned to 8'h10 during dwell → abort, ramps back to 8'h10 with no sign flip.
4. Reset mid-operation: `rst_n`=0 for one edge while `cmd_out`=8'h18 → `cmd_out`=8'h00, `busy`=0 next cycle. Ramp restarts from 0 with the first tick at cycle 4 after release.
5. Stall (macro on):
   - `cmd_in`=8'h40, halls frozen → after 64 cycles with `cur_mag`≠0, `cmd_out` goes to 8'h00 and `stall`=1.
   - Nonzero `cmd_in` keeps the block stalled; `cmd_in`=8'h00 for one cycle clears `stall`.
   - Toggling halls every 32 cycles prevents the stall.
6. Macro off: same stimulus as scenario 5 → `stall` stays 0 and `cmd_out` reaches 8'h40.
